// File: rtl/id_hazard_sequencer.sv
// rtl/id_hazard_sequencer.sv - ID-stage hazard detection, forwarding select and mult/div sequencer
//
// Ports:
//   clock, reset_n                      clock, asynchronous active-low reset
//   ID_Rs/ID_Rt, ID_RsUsed/ID_RtUsed    source operands of the instruction in ID
//   ID_IsBranch                         compare is resolved in ID (needs final operands now)
//   EX_/M_/WB_Rw, *_RegWrite, *_MemRead destination info of the downstream stages
//   MD_Start, MD_IsDiv, MD_Read         mult/div issue, kind, and mfhi/mflo read
//   ID_Exception_Flush                  squash of the ID instruction
//   ID_Stall                            hold IF/ID, bubble ID/EX
//   ID_RsFwdSel/ID_RtFwdSel             00 RF, 01 M, 10 WB
//   MD_Busy, MD_Done                    mult/div occupied / one-cycle completion pulse
//   StallCount                          saturating count of stalled cycles
module id_hazard_sequencer #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_RsUsed,
    input  logic        ID_RtUsed,
    input  logic        ID_IsBranch,
    input  logic [4:0]  EX_Rw,
    input  logic [4:0]  M_Rw,
    input  logic [4:0]  WB_Rw,
    input  logic        EX_RegWrite,
    input  logic        M_RegWrite,
    input  logic        WB_RegWrite,
    input  logic        EX_MemRead,
    input  logic        M_MemRead,
    input  logic        MD_Start,
    input  logic        MD_IsDiv,
    input  logic        MD_Read,
    input  logic        ID_Exception_Flush,
    output logic        ID_Stall,
    output logic [1:0]  ID_RsFwdSel,
    output logic [1:0]  ID_RtFwdSel,
    output logic        MD_Busy,
    output logic        MD_Done,
    output logic [31:0] StallCount
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } md_state_e;

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    md_state_e   state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    function automatic logic reg_match(input logic used, input logic [4:0] src,
                                       input logic we, input logic [4:0] rw);
        return used && (src != 5'd0) && we && (rw == src);
    endfunction

    logic ex_rs, ex_rt, m_rs, m_rt, wb_rs, wb_rt;
    logic load_use_hz, branch_hz, md_hz, md_accept;
    logic [5:0] md_load;

    assign ex_rs = reg_match(ID_RsUsed, ID_Rs, EX_RegWrite, EX_Rw);
    assign ex_rt = reg_match(ID_RtUsed, ID_Rt, EX_RegWrite, EX_Rw);
    assign m_rs  = reg_match(ID_RsUsed, ID_Rs, M_RegWrite,  M_Rw);
    assign m_rt  = reg_match(ID_RtUsed, ID_Rt, M_RegWrite,  M_Rw);
    assign wb_rs = reg_match(ID_RsUsed, ID_Rs, WB_RegWrite, WB_Rw);
    assign wb_rt = reg_match(ID_RtUsed, ID_Rt, WB_RegWrite, WB_Rw);

    assign MD_Busy = (state_q == S_BUSY);
    assign MD_Done = (state_q == S_DONE);

    // A branch compares in ID, so any EX result is too late, and an M-stage
    // load has no data to forward yet.
    assign load_use_hz = EX_MemRead & (ex_rs | ex_rt);
    assign branch_hz   = ID_IsBranch & ((ex_rs | ex_rt) | (M_MemRead & (m_rs | m_rt)));
    assign md_hz       = MD_Busy & (MD_Start | MD_Read);
    assign ID_Stall    = (load_use_hz | branch_hz | md_hz) & ~ID_Exception_Flush;

    // A load in M has no data yet, so it falls through to WB or the RF.
    assign ID_RsFwdSel = (m_rs & ~M_MemRead) ? 2'b01 : (wb_rs ? 2'b10 : 2'b00);
    assign ID_RtFwdSel = (m_rt & ~M_MemRead) ? 2'b01 : (wb_rt ? 2'b10 : 2'b00);

    assign md_load   = MD_IsDiv ? DIV_LOAD : MUL_LOAD;
    assign md_accept = MD_Start & ~ID_Stall & ~ID_Exception_Flush & ~MD_Busy;

    // The counter holds the cycles remaining after the current BUSY cycle, so
    // the last BUSY cycle is the one where it reads 1 and DONE lands at T+N.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (md_accept) begin
                    cnt_d   = md_load;
                    state_d = (md_load == 6'd0) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q <= 6'd1) begin
                    cnt_d   = 6'd0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ID_Stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 6'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_id_hazard_sequencer.sv
// tb/tb_id_hazard_sequencer.sv - self-checking bench for id_hazard_sequencer
module tb_id_hazard_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [4:0]  ID_Rs, ID_Rt, EX_Rw, M_Rw, WB_Rw;
    logic        ID_RsUsed, ID_RtUsed, ID_IsBranch;
    logic        EX_RegWrite, M_RegWrite, WB_RegWrite, EX_MemRead, M_MemRead;
    logic        MD_Start, MD_IsDiv, MD_Read, ID_Exception_Flush;
    logic        ID_Stall, MD_Busy, MD_Done;
    logic [1:0]  ID_RsFwdSel, ID_RtFwdSel;
    logic [31:0] StallCount;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    id_hazard_sequencer #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_RsUsed(ID_RsUsed), .ID_RtUsed(ID_RtUsed),
        .ID_IsBranch(ID_IsBranch),
        .EX_Rw(EX_Rw), .M_Rw(M_Rw), .WB_Rw(WB_Rw),
        .EX_RegWrite(EX_RegWrite), .M_RegWrite(M_RegWrite), .WB_RegWrite(WB_RegWrite),
        .EX_MemRead(EX_MemRead), .M_MemRead(M_MemRead),
        .MD_Start(MD_Start), .MD_IsDiv(MD_IsDiv), .MD_Read(MD_Read),
        .ID_Exception_Flush(ID_Exception_Flush),
        .ID_Stall(ID_Stall), .ID_RsFwdSel(ID_RsFwdSel), .ID_RtFwdSel(ID_RtFwdSel),
        .MD_Busy(MD_Busy), .MD_Done(MD_Done), .StallCount(StallCount)
    );

    typedef struct {
        logic [4:0] rs, rt;
        logic       rsu, rtu, br;
        logic [4:0] exrw;
        logic       exw, exmr;
        logic [4:0] mrw;
        logic       mw, mmr;
        logic [4:0] wbrw;
        logic       wbw;
        logic       stall;
        logic [1:0] fs, ft;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                                input logic rtu, input logic br,
                                input logic [4:0] exrw, input logic exw, input logic exmr,
                                input logic [4:0] mrw, input logic mw, input logic mmr,
                                input logic [4:0] wbrw, input logic wbw,
                                input logic stall, input logic [1:0] fs, input logic [1:0] ft);
        vec_t v;
        v.rs = rs; v.rsu = rsu; v.rt = rt; v.rtu = rtu; v.br = br;
        v.exrw = exrw; v.exw = exw; v.exmr = exmr;
        v.mrw = mrw; v.mw = mw; v.mmr = mmr;
        v.wbrw = wbrw; v.wbw = wbw;
        v.stall = stall; v.fs = fs; v.ft = ft;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        ID_Rs = 0; ID_Rt = 0; ID_RsUsed = 0; ID_RtUsed = 0; ID_IsBranch = 0;
        EX_Rw = 0; M_Rw = 0; WB_Rw = 0;
        EX_RegWrite = 0; M_RegWrite = 0; WB_RegWrite = 0; EX_MemRead = 0; M_MemRead = 0;
        MD_Start = 0; MD_IsDiv = 0; MD_Read = 0; ID_Exception_Flush = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        step();
        step();
        reset_n = 1'b1;
    endtask

    // Reference model: an operation accepted at cycle t with latency n is busy
    // over (t, t+n) and completes at t+n.
    int          cyc;
    int          op_t;
    int          op_n;
    bit          op_v;
    int unsigned sc_m;

    function automatic bit m_match(input bit used, input int src, input bit we, input int rw);
        return used && src != 0 && we && rw == src;
    endfunction

    function automatic logic [1:0] m_fwd(input bit used, input int src);
        if (m_match(used, src, M_RegWrite, M_Rw) && !M_MemRead) return 2'b01;
        if (m_match(used, src, WB_RegWrite, WB_Rw)) return 2'b10;
        return 2'b00;
    endfunction

    initial begin
        bit   busy_e, done_e, stall_e, ex_hit, m_hit;
        int   n_sel;

        vecs[0]  = mk(5, 1, 0, 0, 0,  5, 1, 1,  0, 0, 0,  0, 0,  1, 2'b00, 2'b00);
        vecs[1]  = mk(5, 1, 0, 0, 0,  0, 1, 1,  0, 0, 0,  0, 0,  0, 2'b00, 2'b00);
        vecs[2]  = mk(0, 0, 7, 1, 0,  0, 0, 0,  7, 1, 0,  7, 1,  0, 2'b00, 2'b01);
        vecs[3]  = mk(0, 0, 7, 1, 0,  0, 0, 0,  7, 1, 1,  7, 1,  0, 2'b00, 2'b10);
        vecs[4]  = mk(0, 0, 7, 1, 1,  0, 0, 0,  7, 1, 1,  7, 1,  1, 2'b00, 2'b10);
        vecs[5]  = mk(3, 1, 0, 0, 1,  3, 1, 0,  0, 0, 0,  0, 0,  1, 2'b00, 2'b00);
        vecs[6]  = mk(3, 1, 0, 0, 0,  3, 1, 0,  0, 0, 0,  0, 0,  0, 2'b00, 2'b00);
        vecs[7]  = mk(0, 1, 0, 1, 1,  0, 1, 1,  0, 1, 1,  0, 1,  0, 2'b00, 2'b00);
        vecs[8]  = mk(5, 0, 0, 0, 0,  5, 1, 1,  0, 0, 0,  0, 0,  0, 2'b00, 2'b00);
        vecs[9]  = mk(9, 1, 0, 0, 0,  0, 0, 0,  9, 0, 0,  9, 1,  0, 2'b10, 2'b00);
        vecs[10] = mk(4, 1, 6, 1, 0,  0, 0, 0,  4, 1, 0,  6, 1,  0, 2'b01, 2'b10);

        do_reset();
        #1;
        chk("rst_busy", 32'(MD_Busy), 32'd0);
        chk("rst_done", 32'(MD_Done), 32'd0);
        chk("rst_count", StallCount, 32'd0);
        chk("rst_stall", 32'(ID_Stall), 32'd0);

        // combinational vectors with the mult/div unit idle
        for (int i = 0; i < 11; i++) begin
            ID_Rs = vecs[i].rs; ID_RsUsed = vecs[i].rsu;
            ID_Rt = vecs[i].rt; ID_RtUsed = vecs[i].rtu; ID_IsBranch = vecs[i].br;
            EX_Rw = vecs[i].exrw; EX_RegWrite = vecs[i].exw; EX_MemRead = vecs[i].exmr;
            M_Rw = vecs[i].mrw; M_RegWrite = vecs[i].mw; M_MemRead = vecs[i].mmr;
            WB_Rw = vecs[i].wbrw; WB_RegWrite = vecs[i].wbw;
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(ID_Stall), 32'(vecs[i].stall));
            chk($sformatf("vec%0d_rsfwd", i), 32'(ID_RsFwdSel), 32'(vecs[i].fs));
            chk($sformatf("vec%0d_rtfwd", i), 32'(ID_RtFwdSel), 32'(vecs[i].ft));
            // a flush masks every stall source
            ID_Exception_Flush = 1'b1;
            #1;
            chk($sformatf("vec%0d_flushmask", i), 32'(ID_Stall), 32'd0);
            ID_Exception_Flush = 1'b0;
        end

        // divide: busy T+1..T+31, done at T+32, reads stall only while busy
        do_reset();
        MD_Start = 1; MD_IsDiv = 1;
        #1;
        chk("div_start_stall", 32'(ID_Stall), 32'd0);
        step();
        MD_Start = 0; MD_IsDiv = 0;
        for (int k = 1; k < 32; k++) begin
            MD_Read = 1;
            #1;
            chk($sformatf("div_busy_t%0d", k), 32'(MD_Busy), 32'd1);
            chk($sformatf("div_done_t%0d", k), 32'(MD_Done), 32'd0);
            chk($sformatf("div_rdstall_t%0d", k), 32'(ID_Stall), 32'd1);
            step();
        end
        #1;
        chk("div_busy_t32", 32'(MD_Busy), 32'd0);
        chk("div_done_t32", 32'(MD_Done), 32'd1);
        chk("div_rdstall_t32", 32'(ID_Stall), 32'd0);
        chk("div_stallcount", StallCount, 32'd31);
        MD_Read = 0;
        step();
        chk("div_done_t33", 32'(MD_Done), 32'd0);

        // flushed start never leaves IDLE
        MD_Start = 1; ID_Exception_Flush = 1;
        #1;
        chk("flush_start_stall", 32'(ID_Stall), 32'd0);
        step();
        MD_Start = 0; ID_Exception_Flush = 0;
        chk("flush_start_busy", 32'(MD_Busy), 32'd0);
        step();
        chk("flush_start_done", 32'(MD_Done), 32'd0);

        // flush during a running mult does not abort it
        MD_Start = 1; MD_IsDiv = 0;
        step();
        MD_Start = 0;
        step();
        step();
        ID_Exception_Flush = 1;
        #1;
        chk("mul_t3_busy", 32'(MD_Busy), 32'd1);
        step();
        ID_Exception_Flush = 0;
        chk("mul_t4_done", 32'(MD_Done), 32'd1);
        chk("mul_t4_busy", 32'(MD_Busy), 32'd0);

        // reset at T+10 of a divide
        MD_Start = 1; MD_IsDiv = 1;
        step();
        MD_Start = 0; MD_IsDiv = 0; MD_Read = 1;
        for (int k = 1; k < 10; k++) step();
        chk("rstdiv_busy_before", 32'(MD_Busy), 32'd1);
        reset_n = 0;
        #1;
        chk("rstdiv_busy", 32'(MD_Busy), 32'd0);
        chk("rstdiv_count", StallCount, 32'd0);
        chk("rstdiv_done", 32'(MD_Done), 32'd0);
        MD_Read = 0;
        step();
        reset_n = 1;
        begin
            int seen = 0;
            for (int k = 0; k < 40; k++) begin
                step();
                if (MD_Done) seen++;
            end
            chk("rstdiv_no_done", 32'(seen), 32'd0);
        end

        // StallCount saturation
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        #1;
        chk("sat_preload", StallCount, 32'hFFFF_FFFE);
        ID_Rs = 5; ID_RsUsed = 1; EX_Rw = 5; EX_RegWrite = 1; EX_MemRead = 1;
        step();
        chk("sat_1", StallCount, 32'hFFFF_FFFF);
        step();
        step();
        chk("sat_3", StallCount, 32'hFFFF_FFFF);

        // randomized run against the reference model
        do_reset();
        cyc = 0; op_v = 0; op_t = 0; op_n = 0; sc_m = 0;
        for (int i = 0; i < 1500; i++) begin
            ID_Rs = 5'($urandom_range(0, 3)); ID_Rt = 5'($urandom_range(0, 3));
            EX_Rw = 5'($urandom_range(0, 3)); M_Rw = 5'($urandom_range(0, 3));
            WB_Rw = 5'($urandom_range(0, 3));
            ID_RsUsed = 1'($urandom_range(0, 1)); ID_RtUsed = 1'($urandom_range(0, 1));
            ID_IsBranch = ($urandom_range(0, 3) == 0);
            EX_RegWrite = ($urandom_range(0, 3) != 0);
            M_RegWrite = ($urandom_range(0, 3) != 0);
            WB_RegWrite = ($urandom_range(0, 3) != 0);
            EX_MemRead = ($urandom_range(0, 2) == 0);
            M_MemRead = ($urandom_range(0, 2) == 0);
            MD_Start = ($urandom_range(0, 2) == 0);
            MD_IsDiv = ($urandom_range(0, 3) == 0);
            MD_Read = ($urandom_range(0, 3) == 0);
            ID_Exception_Flush = ($urandom_range(0, 7) == 0);
            #1;
            busy_e = op_v && cyc > op_t && cyc < op_t + op_n;
            done_e = op_v && cyc == op_t + op_n;
            ex_hit = m_match(ID_RsUsed, ID_Rs, EX_RegWrite, EX_Rw) ||
                     m_match(ID_RtUsed, ID_Rt, EX_RegWrite, EX_Rw);
            m_hit  = m_match(ID_RsUsed, ID_Rs, M_RegWrite, M_Rw) ||
                     m_match(ID_RtUsed, ID_Rt, M_RegWrite, M_Rw);
            stall_e = !ID_Exception_Flush &&
                      ((EX_MemRead && ex_hit) ||
                       (ID_IsBranch && (ex_hit || (M_MemRead && m_hit))) ||
                       (busy_e && (MD_Start || MD_Read)));
            chk("rnd_stall", 32'(ID_Stall), 32'(stall_e));
            chk("rnd_rsfwd", 32'(ID_RsFwdSel), 32'(m_fwd(ID_RsUsed, ID_Rs)));
            chk("rnd_rtfwd", 32'(ID_RtFwdSel), 32'(m_fwd(ID_RtUsed, ID_Rt)));
            chk("rnd_busy", 32'(MD_Busy), 32'(busy_e));
            chk("rnd_done", 32'(MD_Done), 32'(done_e));
            chk("rnd_count", StallCount, sc_m);
            if (stall_e && sc_m != 32'hFFFF_FFFF) sc_m++;
            if (MD_Start && !stall_e && !ID_Exception_Flush && !busy_e) begin
                n_sel = MD_IsDiv ? 32 : 4;
                op_v = 1; op_t = cyc; op_n = n_sel;
            end
            step();
            cyc++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
